// File: rtl/execute_stage.sv
// EX stage: forwarding muxes, single-cycle ALU, branch/jump resolution and
// a 32-step radix-4 multiplier that stalls the pipe while it runs.
module execute_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteEnE,
  input  logic        MemtoRegE,
  input  logic        JALE,
  input  logic        MemReadEnE,
  input  logic        MemWriteEnE,
  input  logic        JALRE,
  input  logic        BranchE,
  input  logic [2:0]  BranchTypeE,
  input  logic [3:0]  ALUControlE,
  input  logic        ALUSrcE,
  input  logic [1:0]  MemSizeE,
  input  logic [1:0]  LoadSizeE,
  input  logic [4:0]  RdE,
  input  logic [63:0] RD1E,
  input  logic [63:0] RD2E,
  input  logic [63:0] ImmE,
  input  logic [63:0] PcE,
  input  logic [63:0] PcPlus4E,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  input  logic [63:0] ResultW,
  input  logic        FlushE,
  output logic        PCSrcE,
  output logic [63:0] PcTargetE,
  output logic        BusyE,
  output logic        RegWriteEnM,
  output logic        MemtoRegM,
  output logic        JALM,
  output logic        MemReadEnM,
  output logic        MemWriteEnM,
  output logic [1:0]  MemSizeM,
  output logic [1:0]  LoadSizeM,
  output logic [4:0]  RdM,
  output logic [63:0] PcPlus4M,
  output logic [63:0] ReadData2M,
  output logic [63:0] ALUResultM
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  localparam logic [3:0] OP_MUL = 4'b1010;

  state_t      r_state, w_state_nxt;
  logic [63:0] r_mcand, r_mplier, r_acc;
  logic [4:0]  r_cnt;

  logic [63:0] w_src_a, w_fwd_b, w_src_b, w_alu, w_partial;
  logic [5:0]  w_shamt;
  logic        w_cond, w_mul_start;

  always_comb begin
    w_src_a = RD1E;
    case (ForwardAE)
      2'b01:   w_src_a = ResultW;
      2'b10:   w_src_a = ALUResultM;
      default: w_src_a = RD1E;
    endcase
    w_fwd_b = RD2E;
    case (ForwardBE)
      2'b01:   w_fwd_b = ResultW;
      2'b10:   w_fwd_b = ALUResultM;
      default: w_fwd_b = RD2E;
    endcase
  end

  assign w_src_b = ALUSrcE ? ImmE : w_fwd_b;
  assign w_shamt = w_src_b[5:0];

  // MUL is not produced here; the product comes from the multiplier in DONE.
  always_comb begin
    w_alu = '0;
    case (ALUControlE)
      4'b0000: w_alu = w_src_a + w_src_b;
      4'b0001: w_alu = w_src_a - w_src_b;
      4'b0010: w_alu = w_src_a & w_src_b;
      4'b0011: w_alu = w_src_a | w_src_b;
      4'b0100: w_alu = w_src_a ^ w_src_b;
      4'b0101: w_alu = w_src_a << w_shamt;
      4'b0110: w_alu = w_src_a >> w_shamt;
      4'b0111: w_alu = $signed(w_src_a) >>> w_shamt;
      4'b1000: w_alu = {63'd0, $signed(w_src_a) < $signed(w_src_b)};
      4'b1001: w_alu = {63'd0, w_src_a < w_src_b};
      default: w_alu = '0;
    endcase
  end

  // Branches always compare against the forwarded rs2, never the immediate.
  always_comb begin
    w_cond = 1'b0;
    case (BranchTypeE)
      3'b000:  w_cond = (w_src_a == w_fwd_b);
      3'b001:  w_cond = (w_src_a != w_fwd_b);
      3'b100:  w_cond = ($signed(w_src_a) <  $signed(w_fwd_b));
      3'b101:  w_cond = ($signed(w_src_a) >= $signed(w_fwd_b));
      3'b110:  w_cond = (w_src_a <  w_fwd_b);
      3'b111:  w_cond = (w_src_a >= w_fwd_b);
      default: w_cond = 1'b0;
    endcase
  end

  assign PcTargetE = JALRE ? ((w_src_a + ImmE) & ~64'd1) : (PcE + ImmE);
  assign PCSrcE    = ~FlushE & (JALE | JALRE | (BranchE & w_cond));

  assign w_mul_start = (r_state == S_IDLE) && (ALUControlE == OP_MUL) && !FlushE;
  assign BusyE       = rst & (w_mul_start | (r_state == S_MUL));

  always_comb begin
    w_state_nxt = r_state;
    if (FlushE) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_mul_start) w_state_nxt = S_MUL;
        S_MUL:   if (r_cnt == 5'd31) w_state_nxt = S_DONE;
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_partial = '0;
    case (r_mplier[1:0])
      2'b01:   w_partial = r_mcand;
      2'b10:   w_partial = {r_mcand[62:0], 1'b0};
      2'b11:   w_partial = {r_mcand[62:0], 1'b0} + r_mcand;
      default: w_partial = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_mul_start) begin
        r_mcand  <= w_src_a;
        r_mplier <= w_src_b;
        r_acc    <= '0;
        r_cnt    <= '0;
      end
    end else if (r_state == S_MUL) begin
      r_acc    <= r_acc + w_partial;
      r_mcand  <= {r_mcand[61:0], 2'b00};
      r_mplier <= {2'b00, r_mplier[63:2]};
      r_cnt    <= r_cnt + 5'd1;
    end
  end

  // Stall or flush inserts a bubble: control cleared, data fields held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteEnM <= 1'b0;
      MemtoRegM   <= 1'b0;
      JALM        <= 1'b0;
      MemReadEnM  <= 1'b0;
      MemWriteEnM <= 1'b0;
      MemSizeM    <= '0;
      LoadSizeM   <= '0;
      RdM         <= '0;
      PcPlus4M    <= '0;
      ReadData2M  <= '0;
      ALUResultM  <= '0;
    end else if (FlushE || BusyE) begin
      RegWriteEnM <= 1'b0;
      MemtoRegM   <= 1'b0;
      JALM        <= 1'b0;
      MemReadEnM  <= 1'b0;
      MemWriteEnM <= 1'b0;
    end else begin
      RegWriteEnM <= RegWriteEnE;
      MemtoRegM   <= MemtoRegE;
      JALM        <= JALE;
      MemReadEnM  <= MemReadEnE;
      MemWriteEnM <= MemWriteEnE;
      MemSizeM    <= MemSizeE;
      LoadSizeM   <= LoadSizeE;
      RdM         <= RdE;
      PcPlus4M    <= PcPlus4E;
      ReadData2M  <= w_fwd_b;
      ALUResultM  <= (r_state == S_DONE) ? r_acc : w_alu;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: expected M-stage results are queued when
// an instruction is driven and compared when it reaches the M registers.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteEnE, MemtoRegE, JALE, MemReadEnE, MemWriteEnE;
  logic        JALRE, BranchE, ALUSrcE, FlushE;
  logic [2:0]  BranchTypeE;
  logic [3:0]  ALUControlE;
  logic [1:0]  MemSizeE, LoadSizeE, ForwardAE, ForwardBE;
  logic [4:0]  RdE;
  logic [63:0] RD1E, RD2E, ImmE, PcE, PcPlus4E, ResultW;
  logic        PCSrcE, BusyE;
  logic [63:0] PcTargetE;
  logic        RegWriteEnM, MemtoRegM, JALM, MemReadEnM, MemWriteEnM;
  logic [1:0]  MemSizeM, LoadSizeM;
  logic [4:0]  RdM;
  logic [63:0] PcPlus4M, ReadData2M, ALUResultM;

  execute_stage dut (
    .clk(clk), .rst(rst),
    .RegWriteEnE(RegWriteEnE), .MemtoRegE(MemtoRegE), .JALE(JALE),
    .MemReadEnE(MemReadEnE), .MemWriteEnE(MemWriteEnE),
    .JALRE(JALRE), .BranchE(BranchE), .BranchTypeE(BranchTypeE),
    .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
    .MemSizeE(MemSizeE), .LoadSizeE(LoadSizeE), .RdE(RdE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmE(ImmE), .PcE(PcE), .PcPlus4E(PcPlus4E),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
    .FlushE(FlushE),
    .PCSrcE(PCSrcE), .PcTargetE(PcTargetE), .BusyE(BusyE),
    .RegWriteEnM(RegWriteEnM), .MemtoRegM(MemtoRegM), .JALM(JALM),
    .MemReadEnM(MemReadEnM), .MemWriteEnM(MemWriteEnM),
    .MemSizeM(MemSizeM), .LoadSizeM(LoadSizeM), .RdM(RdM),
    .PcPlus4M(PcPlus4M), .ReadData2M(ReadData2M), .ALUResultM(ALUResultM)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] alu;
    logic [63:0] rd2;
    logic [4:0]  rd;
    logic        rw;
    logic        jal;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  localparam int NT = 12;
  localparam logic [3:0]  T_OP [NT] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                                        4'h7, 4'h8, 4'h9, 4'hB, 4'h0, 4'hF};
  localparam logic [63:0] T_A [NT] = '{64'd0, 64'hF0F0, 64'hF0F0, 64'hFFFF, 64'd1,
                                       64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                                       '1, '1, 64'd5, '1, 64'd5};
  localparam logic [63:0] T_B [NT] = '{64'd1, 64'hFF00, 64'h0F0F, 64'h00FF, 64'h41,
                                       64'd63, 64'd4, 64'd1, 64'd1, 64'd3, 64'd2, 64'd3};
  localparam logic [63:0] T_Y [NT] = '{'1, 64'hF000, 64'hFFFF, 64'hFF00, 64'd2, 64'd1,
                                       64'hF800_0000_0000_0000, 64'd1, 64'd0, 64'd0,
                                       64'd1, 64'd0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    RegWriteEnE = 0; MemtoRegE = 0; JALE = 0; MemReadEnE = 0; MemWriteEnE = 0;
    JALRE = 0; BranchE = 0; BranchTypeE = 0; ALUControlE = 0; ALUSrcE = 0;
    MemSizeE = 0; LoadSizeE = 0; RdE = 0; RD1E = 0; RD2E = 0; ImmE = 0;
    PcE = 0; PcPlus4E = 0; ForwardAE = 0; ForwardBE = 0; ResultW = 0; FlushE = 0;
  endtask

  task automatic expect_m(input string tag, input logic [63:0] alu, input logic [63:0] rd2,
                          input logic [4:0] rd, input logic rw, input logic jal);
    exp_t e;
    e.alu = alu; e.rd2 = rd2; e.rd = rd; e.rw = rw; e.jal = jal;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_m();
    exp_t  e;
    string t;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd1);
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    chk({t, ".alu"}, ALUResultM, e.alu);
    chk({t, ".rd2"}, ReadData2M, e.rd2);
    chk({t, ".rd"},  64'(RdM), 64'(e.rd));
    chk({t, ".rw"},  64'(RegWriteEnM), 64'(e.rw));
    chk({t, ".jal"}, 64'(JALM), 64'(e.jal));
  endtask

  // Drives a MUL and follows it through the stall to its M-stage result.
  task automatic run_mul(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] rd, input logic [63:0] prod);
    int busy_cycles = 0;
    int bad_ctrl = 0;
    int guard = 0;
    clear_inputs();
    ALUControlE = 4'b1010; RD1E = a; RD2E = b; RegWriteEnE = 1; RdE = rd;
    expect_m(tag, prod, b, rd, 1'b1, 1'b0);
    #1;
    if (BusyE) busy_cycles++;
    while (BusyE && guard < 100) begin
      tick();
      guard++;
      if (BusyE) busy_cycles++;
      if (RegWriteEnM !== 1'b0 || JALM !== 1'b0 || MemWriteEnM !== 1'b0) bad_ctrl++;
    end
    chk({tag, ".busy_cycles"}, 64'(busy_cycles), 64'd33);
    chk({tag, ".bubble_ctrl"}, 64'(bad_ctrl), 64'd0);
    tick();
    check_m();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    clear_inputs();
    rst = 1'b0;
    ALUControlE = 4'b1010;
    #2;
    chk("reset.busy", 64'(BusyE), 64'd0);
    chk("reset.alu", ALUResultM, 64'd0);
    chk("reset.ctrl", 64'({RegWriteEnM, MemtoRegM, JALM, MemReadEnM, MemWriteEnM}), 64'd0);
    chk("reset.data", 64'({MemSizeM, LoadSizeM, RdM}) | PcPlus4M | ReadData2M, 64'd0);
    clear_inputs();
    #10 rst = 1'b1;
    tick();

    // ADD with immediate; ReadData2M must take rs2, not the immediate
    ALUControlE = 4'b0000; RD1E = 64'd5; ImmE = -64'sd7; ALUSrcE = 1; RD2E = 64'hABCD;
    RegWriteEnE = 1; RdE = 5'd3;
    expect_m("add_imm", 64'hFFFF_FFFF_FFFF_FFFE, 64'hABCD, 5'd3, 1'b1, 1'b0);
    #1 chk("add_imm.busy", 64'(BusyE), 64'd0);
    tick();
    check_m();

    for (int i = 0; i < NT; i++) begin
      clear_inputs();
      ALUControlE = T_OP[i]; RD1E = T_A[i]; RD2E = T_B[i]; RegWriteEnE = 1; RdE = 5'(i + 1);
      expect_m($sformatf("alu%0d", i), T_Y[i], T_B[i], 5'(i + 1), 1'b1, 1'b0);
      tick();
      check_m();
    end

    clear_inputs();
    ALUControlE = 4'b0000; RD1E = 64'd1; RD2E = 64'h99; ForwardBE = 2'b01; ResultW = 64'h55;
    RegWriteEnE = 1; RdE = 5'd7;
    expect_m("fwd_b_w", 64'h56, 64'h55, 5'd7, 1'b1, 1'b0);
    tick();
    check_m();

    clear_inputs();
    RD1E = 64'h10; RegWriteEnE = 1; RdE = 5'd8;
    expect_m("set_alum", 64'h10, 64'd0, 5'd8, 1'b1, 1'b0);
    tick();
    check_m();

    // Branches: rs1 forwarded from ALUResultM, immediate differs from rs2
    clear_inputs();
    ForwardAE = 2'b10; RD1E = 64'hDEAD; RD2E = 64'h10; ALUSrcE = 1; ImmE = 64'h20;
    PcE = 64'h100; BranchE = 1; BranchTypeE = 3'b000;
    #1;
    chk("beq.pcsrc", 64'(PCSrcE), 64'd1);
    chk("beq.target", PcTargetE, 64'h120);
    BranchTypeE = 3'b001;
    #1 chk("bne.pcsrc", 64'(PCSrcE), 64'd0);
    BranchTypeE = 3'b000; FlushE = 1;
    #1 chk("beq_flush.pcsrc", 64'(PCSrcE), 64'd0);
    tick();

    clear_inputs();
    ForwardAE = 2'b01; ResultW = '1; RD1E = 64'd5; RD2E = 64'd1; BranchE = 1;
    BranchTypeE = 3'b100;
    #1 chk("blt.pcsrc", 64'(PCSrcE), 64'd1);
    BranchTypeE = 3'b101;
    #1 chk("bge.pcsrc", 64'(PCSrcE), 64'd0);
    BranchTypeE = 3'b110;
    #1 chk("bltu.pcsrc", 64'(PCSrcE), 64'd0);
    BranchTypeE = 3'b111;
    #1 chk("bgeu.pcsrc", 64'(PCSrcE), 64'd1);
    tick();

    clear_inputs();
    JALRE = 1; JALE = 1; RD1E = 64'h1003; ImmE = 64'd0; ALUSrcE = 1; RegWriteEnE = 1;
    RdE = 5'd1; PcE = 64'h5000; PcPlus4E = 64'h2004; MemtoRegE = 1; MemReadEnE = 1;
    MemWriteEnE = 1; MemSizeE = 2'b10; LoadSizeE = 2'b01;
    expect_m("jalr", 64'h1003, 64'd0, 5'd1, 1'b1, 1'b1);
    #1;
    chk("jalr.target", PcTargetE, 64'h1002);
    chk("jalr.pcsrc", 64'(PCSrcE), 64'd1);
    tick();
    check_m();
    chk("jalr.pcplus4", PcPlus4M, 64'h2004);
    chk("jalr.memctl", 64'({MemtoRegM, MemReadEnM, MemWriteEnM, MemSizeM, LoadSizeM}),
        64'b111_10_01);

    run_mul("mul_neg", -64'sd3, 64'd7, 5'd9, 64'hFFFF_FFFF_FFFF_FFEB);
    run_mul("mul_b2b", 64'h1234_5678_9ABC_DEF1, 64'hFEDC_BA98_7654_3211, 5'd10,
            64'h1234_5678_9ABC_DEF1 * 64'hFEDC_BA98_7654_3211);

    clear_inputs();
    RD1E = 64'h70; RD2E = 64'h7; ALUControlE = 4'b0011; RegWriteEnE = 1; RdE = 5'd2;
    expect_m("pre_flush", 64'h77, 64'h7, 5'd2, 1'b1, 1'b0);
    tick();
    check_m();

    // Flush in the middle of a multiply
    clear_inputs();
    ALUControlE = 4'b1010; RD1E = 64'd3; RD2E = 64'd5; RegWriteEnE = 1; RdE = 5'd4;
    repeat (10) tick();
    FlushE = 1;
    tick();
    clear_inputs();
    RD1E = 64'h40; RD2E = 64'h2; RegWriteEnE = 1; RdE = 5'd6;
    expect_m("post_flush_add", 64'h42, 64'h2, 5'd6, 1'b1, 1'b0);
    #1;
    chk("flush.busy", 64'(BusyE), 64'd0);
    chk("flush.rw", 64'(RegWriteEnM), 64'd0);
    chk("flush.alu_held", ALUResultM, 64'h77);
    tick();
    check_m();

    // Flush coinciding with a MUL start
    clear_inputs();
    ALUControlE = 4'b1010; FlushE = 1; RD1E = 64'd9; RD2E = 64'd9; RegWriteEnE = 1;
    #1 chk("flush_start.busy", 64'(BusyE), 64'd0);
    tick();
    chk("flush_start.rw", 64'(RegWriteEnM), 64'd0);
    chk("flush_start.alu_held", ALUResultM, 64'h42);
    clear_inputs();
    RD1E = 64'd4; RD2E = 64'd4; RegWriteEnE = 1; RdE = 5'd5;
    expect_m("after_flush_start", 64'd8, 64'd4, 5'd5, 1'b1, 1'b0);
    #1 chk("flush_start.no_mul", 64'(BusyE), 64'd0);
    tick();
    check_m();

    // Reset in the middle of a multiply
    clear_inputs();
    ALUControlE = 4'b1010; RD1E = 64'd11; RD2E = 64'd13; RegWriteEnE = 1; RdE = 5'd7;
    repeat (20) tick();
    #2 rst = 1'b0;
    #1;
    chk("rst_mul.alu", ALUResultM, 64'd0);
    chk("rst_mul.ctrl", 64'({RegWriteEnM, MemtoRegM, JALM, MemReadEnM, MemWriteEnM}), 64'd0);
    chk("rst_mul.data", 64'(RdM) | ReadData2M | PcPlus4M, 64'd0);
    chk("rst_mul.busy", 64'(BusyE), 64'd0);
    clear_inputs();
    RD1E = 64'd1; RD2E = 64'd1; RegWriteEnE = 1; RdE = 5'd2;
    tick();
    chk("rst_hold.alu", ALUResultM, 64'd0);
    #3 rst = 1'b1;
    expect_m("post_reset_add", 64'd2, 64'd1, 5'd2, 1'b1, 1'b0);
    tick();
    check_m();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 RegWriteEnE, MemtoRegE, JALE, MemReadEnE, MemWriteEnE  input  1 each  ID->EX control bits, forwarded to the M outputs.
REQ-004 JALRE, BranchE  input  1 each  JALR and conditional-branch indicators.
REQ-005 BranchTypeE  input  3  000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
REQ-006 ALUControlE  input  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU, 1010 MUL; other codes produce 0.
REQ-007 ALUSrcE  input  1  1 = operand B is ImmE.
REQ-008 MemSizeE, LoadSizeE  input  2 each  store and load size, passed through.
REQ-009 RdE  input  5  destination register.
REQ-010 RD1E, RD2E, ImmE  input  64 each  register operands and sign-extended immediate.
REQ-011 PcE, PcPlus4E  input  64 each  instruction PC and PC+4.
REQ-012 ForwardAE, ForwardBE  input  2 each  00 register file, 01 ResultW, 10 ALUResultM, 11 register file.
REQ-013 ResultW  input  64  writeback result used for forwarding.
REQ-014 FlushE  input  1  synchronous kill of the instruction in EX.
REQ-015 PCSrcE  output  1  redirect-taken; PcTargetE  output  64  redirect address.
REQ-016 BusyE  output  1  stall request to the hazard unit.
REQ-017 RegWriteEnM, MemtoRegM, JALM, MemReadEnM, MemWriteEnM  output  1 each  registered control bits.
REQ-018 MemSizeM, LoadSizeM  output  2 each; RdM  output  5.
REQ-019 PcPlus4M, ReadData2M, ALUResultM  output  64 each  registered data.

Function
REQ-020 SrcA = forwarded RD1E; FwdB = forwarded RD2E; SrcB = ALUSrcE ? ImmE : FwdB.
REQ-021 ADD and SUB wrap modulo 2^64; shift amount is SrcB[5:0]; SLT and SLTU return 0 or 1.
REQ-022 Branch conditions compare SrcA with FwdB, never with the immediate.
REQ-023 PcTargetE = JALRE ? ((SrcA + ImmE) with bit 0 cleared) : (PcE + ImmE); computed combinationally.
REQ-024 PCSrcE = ~FlushE & (JALE | JALRE | (BranchE & condition)); computed combinationally.
REQ-025 Non-MUL operations have 1-cycle latency: the M registers load the EX values on every clock edge where BusyE = 0.
REQ-026 ReadData2M is loaded from FwdB, not SrcB.
REQ-027 The multiply FSM has three states: IDLE, MUL, DONE.
REQ-028 IDLE -> MUL when ALUControlE = 1010 and FlushE = 0: capture SrcA and SrcB, clear the accumulator, clear a 5-bit counter.
REQ-029 In MUL, each cycle performs a radix-4 shift-add step over 2 multiplier bits; after 32 steps (counter wrap 31 -> 0) the FSM moves to DONE.
REQ-030 DONE -> IDLE unconditionally; on that edge ALUResultM loads product[63:0] and the other M registers load the held E inputs.
REQ-031 BusyE = (IDLE & MUL-start) | MUL; BusyE = 0 in DONE.
REQ-032 While BusyE = 1, the M registers load a bubble: all five control bits 0, data fields unchanged.
REQ-033 Upstream holds all E inputs stable while BusyE = 1; forwarded values captured at the start are the ones used.
REQ-034 MUL total latency: issue edge T, result visible at M after edge T+33; BusyE is high for cycles T through T+32.
REQ-035 FlushE = 1 in any state loads a bubble into M, forces the FSM to IDLE and deasserts BusyE on the next edge.
REQ-036 FlushE together with a MUL start: the FlushE action wins and no multiply begins.
REQ-037 A back-to-back MUL restarts from IDLE; there is no IDLE skip.

Reset
REQ-038 rst = 0 immediately sets the FSM to IDLE, clears the accumulator, counter and captured operands, and clears every M output to 0.
REQ-039 Reset during MUL aborts the multiply; BusyE = 0 while in reset.
REQ-040 After rst deasserts, the first edge with valid E inputs behaves as a normal issue.

Verification
REQ-041 ADD with RD1E=5, ImmE=-7, ALUSrcE=1 -> ALUResultM = 0xFFFF_FFFF_FFFF_FFFE after 1 edge, BusyE = 0.
REQ-042 ForwardAE=10, ALUResultM=0x10, BEQ against FwdB=0x10, PcE=0x100, ImmE=0x20 -> PCSrcE = 1, PcTargetE = 0x120.
REQ-043 JALRE with SrcA=0x1003, ImmE=0 -> PcTargetE = 0x1002, PCSrcE = 1, JALM = 1 after the edge.
REQ-044 MUL with SrcA=-3, SrcB=7 -> BusyE high for 33 cycles, M control bits 0 during that time, then ALUResultM = 0xFFFF_FFFF_FFFF_FFEB.
REQ-045 MUL issued, FlushE pulsed at cycle 10 -> BusyE = 0 next cycle, RegWriteEnM = 0, no product is written.
REQ-046 rst = 0 at cycle 20 of a MUL -> M outputs 0 asynchronously; after release, ADD 1+1 yields ALUResultM = 2.
